tlp_tap_packer: RTL
===================

Name: tlp_tap_packer

Overview:
- Capture-side stage directly upstream of the TLP FIFO consumed by the Eth/IP/UDP encapsulator.
- Snoops a 64-bit PCIe TLP stream with no backpressure, and normalises every TLP to a fixed-length record of TLP_LEN bytes by zero-padding or truncating it.
- Writes each record into the 74-bit FIFO as one contiguous burst, so the encapsulator, once it sees the FIFO non-empty, never underruns mid-frame.
- Ping-pong buffering absorbs back-to-back TLPs; TLPs that do not fit are dropped whole and counted.

Parameters:
- TLP_LEN, 32, record length in bytes; multiple of 8, minimum 16.
- BEATS, TLP_LEN/8, beats per record (derived; do not override).

Ports:
- clk156  in  1  clock, all logic.
- sys_rst  in  1  asynchronous, active-high reset.
- s_tlp_tvalid  in  1  snooped TLP beat valid; no ready is returned.
- s_tlp_tdata  in  64  TLP data, byte order passed through unchanged.
- s_tlp_tkeep  in  8  byte enables; contiguous from bit 0.
- s_tlp_tlast  in  1  last beat of the TLP.
- s_tlp_tuser  in  1  error flag; sampled on any beat.
- wr_en  out  1  FIFO write strobe.
- din  out  74  FIFO word {tkeep[7:0], tdata[63:0], tlast, tuser}.
- prog_full  in  1  FIFO programmable-full; deasserted guarantees ≥BEATS free entries.
- tlp_count  out  32  TLPs written to the FIFO; wraps.
- drop_count  out  32  TLPs dropped because no buffer was free; wraps.
- trunc_count  out  32  TLPs longer than TLP_LEN, truncated; wraps.

Behaviour:
- Reset values: wr_en=0, din=0, all counters=0, both buffers empty, capture idle.
- Reset mid-operation: any partial record or burst is discarded and wr_en drops immediately, since reset is asynchronous.

Buffers:
- Two buffers, each holding BEATS×64 data, a beat count and a sticky error flag, plus a full bit per buffer.
- wr_sel selects the buffer being captured; rd_sel selects the next buffer to emit. Emission is oldest first and alternates strictly.

Capture FSM, states CAP_IDLE, CAP_FILL, CAP_DROP:
- CAP_IDLE, on s_tlp_tvalid (first beat of a TLP):
  - Buffer wr_sel free: store beat 0 and go to CAP_FILL; if tlast is on the same beat, close immediately and stay in CAP_IDLE.
  - Buffer wr_sel full: increment drop_count and go to CAP_DROP; if tlast is on the same beat, stay in CAP_IDLE.
- CAP_FILL, each valid beat:
  - Beat index < BEATS: store the beat. Otherwise discard it and set the local trunc flag.
  - Error flag |= tuser on every beat.
  - On tlast: mark the buffer full, toggle wr_sel, increment trunc_count if the trunc flag is set, return to CAP_IDLE.
- CAP_DROP: ignore beats until tlast, then go to CAP_IDLE.
- Invalid cycles (tvalid=0) inside a TLP are allowed and hold the state.
- On store, bytes whose tkeep bit is 0 are written as 0x00.

Emit FSM, states EM_IDLE, EM_BURST:
- EM_IDLE → EM_BURST when buffer rd_sel is full and prog_full=0. Both conditions are sampled in the same cycle; the first write occurs the next cycle.
- EM_BURST asserts wr_en for exactly BEATS consecutive cycles, with beat index k = 0..BEATS-1. prog_full is ignored during the burst.
- Per beat:
  - din.tkeep = 8'hFF on every beat.
  - din.tdata = stored beat k, or 0 if k ≥ the stored beat count (padding).
  - din.tlast = 1 only when k = BEATS-1.
  - din.tuser = the error flag, on the last beat only; 0 on all other beats.
- After the last beat: clear the buffer's full bit, toggle rd_sel, increment tlp_count, return to EM_IDLE.
- A buffer freed in cycle N is visible to capture in cycle N+1.

Simultaneous events:
- Capture closing buffer X while emit finishes buffer Y is legal; both updates apply in the same cycle.
- A first beat arriving in the cycle a buffer frees sees that buffer as still full and is dropped. This conservative rule is required.
- The counters are independent; each increments at most once per cycle.

Latency: from tlast of a TLP on an idle block with prog_full=0, the first wr_en occurs 2 cycles later.

Test Plan:
- 32B TLP (4 beats, all keep FF, data 0x01..0x04 per beat), prog_full=0 → 4 writes starting 2 cycles after tlast; data matches input; tlast on beat 3; tuser=0; tlp_count=1.
- 12B TLP (beat0 keep FF, beat1 keep 0F with 0xAABBCCDD_EEFF0011) → beat1 upper 4 bytes = 0, beats 2–3 = 0, tkeep FF throughout.
- 48B TLP with tuser=1 on beat 1 → only the first 4 beats are written; tuser=1 on the 4th write; trunc_count=1.
- Three back-to-back 2-beat TLPs, no gaps, prog_full=0 → first two written in order, third dropped; drop_count=1; tlp_count=2.
- prog_full held at 1 while two TLPs arrive, released 20 cycles later → no wr_en while held; two contiguous 4-beat bursts after release, in arrival order.
- sys_rst asserted mid-burst (beat 2) → wr_en=0 in the same cycle; counters = 0; the next TLP is written normally starting from beat 0.

Source files
------------

// File: rtl/tlp_tap_packer.sv
// tlp_tap_packer
//   Sits between a passive PCIe TLP snoop and the TLP FIFO feeding the
//   Eth/IP/UDP encapsulator. Every snooped TLP becomes a fixed record of
//   TLP_LEN bytes, zero-padded or truncated as needed. Each record is written
//   to the FIFO as one unbroken burst of BEATS words, so the reader never
//   underruns mid-frame. Two record buffers (ping-pong) absorb back-to-back
//   TLPs. A TLP that finds no free buffer is dropped whole and counted.
//
// Ports
//   clk156, sys_rst           clock, asynchronous active-high reset
//   s_tlp_t*                  snooped 64-bit TLP stream (no ready)
//   wr_en, din                FIFO write: din = {tkeep, tdata, tlast, tuser}
//   prog_full                 FIFO almost-full; low means room for a record
//   tlp_count                 records written (wraps)
//   drop_count                TLPs dropped, no free buffer (wraps)
//   trunc_count               TLPs longer than TLP_LEN (wraps)
module tlp_tap_packer #(
  parameter int TLP_LEN = 32
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_tlp_tvalid,
  input  logic [63:0] s_tlp_tdata,
  input  logic [7:0]  s_tlp_tkeep,
  input  logic        s_tlp_tlast,
  input  logic        s_tlp_tuser,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        prog_full,
  output logic [31:0] tlp_count,
  output logic [31:0] drop_count,
  output logic [31:0] trunc_count
);

  localparam int DATA_W = 64;
  localparam int BEATS  = TLP_LEN / 8;
  localparam int IDX_W  = $clog2(BEATS + 1);
  localparam int AW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] BEATS_C = IDX_W'(BEATS);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {CAP_IDLE, CAP_FILL, CAP_DROP} cap_state_t;
  typedef enum logic {EM_IDLE, EM_BURST} em_state_t;

  // Bytes with a cleared keep bit are stored as zero.
  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [7:0] k);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  // Emitted word: keep is always all-ones, tuser only rides on the last beat.
  function automatic logic [73:0] emit_word(input logic [DATA_W-1:0] d,
                                            input logic use_data,
                                            input logic last,
                                            input logic err);
    return {8'hFF, (use_data ? d : {DATA_W{1'b0}}), last, last & err};
  endfunction

  cap_state_t        cap_state_q, cap_state_d;
  em_state_t         em_state_q,  em_state_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [1:0]        full_q, full_d;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
  logic              trunc_q, trunc_d;
  logic [IDX_W-1:0]  em_k_q, em_k_d;
  logic              wr_en_q, wr_en_d;
  logic [73:0]       din_q, din_d;
  logic [31:0]       tlp_cnt_q, tlp_cnt_d;
  logic [31:0]       drop_cnt_q, drop_cnt_d;
  logic [31:0]       trunc_cnt_q, trunc_cnt_d;

  logic [DATA_W-1:0] buf_data_q [2][BEATS];
  logic [DATA_W-1:0] buf_data_d [2][BEATS];
  logic [IDX_W-1:0]  buf_cnt_q [2];
  logic [IDX_W-1:0]  buf_cnt_d [2];
  logic [1:0]        buf_err_q, buf_err_d;

  logic [DATA_W-1:0] cap_word;
  logic [IDX_W-1:0]  em_nk;
  logic              trunc_now;

  assign cap_word = mask_bytes(s_tlp_tdata, s_tlp_tkeep);
  assign em_nk    = em_k_q + IDX_W'(1);

  always_comb begin
    cap_state_d = cap_state_q;
    em_state_d  = em_state_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    full_d      = full_q;
    cap_idx_d   = cap_idx_q;
    trunc_d     = trunc_q;
    em_k_d      = em_k_q;
    wr_en_d     = 1'b0;
    din_d       = '0;
    tlp_cnt_d   = tlp_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    buf_data_d  = buf_data_q;
    buf_cnt_d   = buf_cnt_q;
    buf_err_d   = buf_err_q;
    trunc_now   = trunc_q;

    // Capture: snooped beats into buffer wr_sel
    case (cap_state_q)
      CAP_IDLE: begin
        if (s_tlp_tvalid) begin
          // full_q (not full_d) is used, so a buffer freed this cycle still
          // looks busy to a first beat arriving now.
          if (!full_q[wr_sel_q]) begin
            buf_data_d[wr_sel_q][0] = cap_word;
            buf_cnt_d[wr_sel_q]     = IDX_W'(1);
            buf_err_d[wr_sel_q]     = s_tlp_tuser;
            cap_idx_d               = IDX_W'(1);
            trunc_d                 = 1'b0;
            if (s_tlp_tlast) begin
              full_d[wr_sel_q] = 1'b1;
              wr_sel_d         = ~wr_sel_q;
            end else begin
              cap_state_d = CAP_FILL;
            end
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            if (!s_tlp_tlast) cap_state_d = CAP_DROP;
          end
        end
      end
      CAP_FILL: begin
        if (s_tlp_tvalid) begin
          if (cap_idx_q < BEATS_C) begin
            buf_data_d[wr_sel_q][cap_idx_q[AW-1:0]] = cap_word;
            buf_cnt_d[wr_sel_q] = cap_idx_q + IDX_W'(1);
            cap_idx_d           = cap_idx_q + IDX_W'(1);
          end else begin
            trunc_now = 1'b1;
          end
          trunc_d             = trunc_now;
          buf_err_d[wr_sel_q] = buf_err_q[wr_sel_q] | s_tlp_tuser;
          if (s_tlp_tlast) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
            if (trunc_now) trunc_cnt_d = trunc_cnt_q + 32'd1;
            cap_state_d = CAP_IDLE;
          end
        end
      end
      CAP_DROP: begin
        if (s_tlp_tvalid && s_tlp_tlast) cap_state_d = CAP_IDLE;
      end
      default: cap_state_d = CAP_IDLE;
    endcase

    // Emit: buffer rd_sel out to the FIFO; wr_en/din are registered, so the
    // word for beat k is prepared in the cycle before it appears.
    case (em_state_q)
      EM_IDLE: begin
        if (full_q[rd_sel_q] && !prog_full) begin
          em_state_d = EM_BURST;
          em_k_d     = '0;
          wr_en_d    = 1'b1;
          din_d      = emit_word(buf_data_q[rd_sel_q][0],
                                 buf_cnt_q[rd_sel_q] != '0,
                                 LAST_C == '0, buf_err_q[rd_sel_q]);
        end
      end
      EM_BURST: begin
        if (em_k_q == LAST_C) begin
          full_d[rd_sel_q] = 1'b0;
          rd_sel_d         = ~rd_sel_q;
          tlp_cnt_d        = tlp_cnt_q + 32'd1;
          em_state_d       = EM_IDLE;
        end else begin
          em_k_d  = em_nk;
          wr_en_d = 1'b1;
          din_d   = emit_word(buf_data_q[rd_sel_q][em_nk[AW-1:0]],
                              em_nk < buf_cnt_q[rd_sel_q],
                              em_nk == LAST_C, buf_err_q[rd_sel_q]);
        end
      end
      default: em_state_d = EM_IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk156 or posedge sys_rst) begin
    if (sys_rst) begin
      cap_state_q <= CAP_IDLE;
      em_state_q  <= EM_IDLE;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      full_q      <= '0;
      cap_idx_q   <= '0;
      trunc_q     <= 1'b0;
      em_k_q      <= '0;
      wr_en_q     <= 1'b0;
      din_q       <= '0;
      tlp_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      trunc_cnt_q <= '0;
    end else begin
      cap_state_q <= cap_state_d;
      em_state_q  <= em_state_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      full_q      <= full_d;
      cap_idx_q   <= cap_idx_d;
      trunc_q     <= trunc_d;
      em_k_q      <= em_k_d;
      wr_en_q     <= wr_en_d;
      din_q       <= din_d;
      tlp_cnt_q   <= tlp_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  // Record storage; only meaningful while the matching full bit is set
  always_ff @(posedge clk156) begin
    buf_data_q <= buf_data_d;
    buf_cnt_q  <= buf_cnt_d;
    buf_err_q  <= buf_err_d;
  end

  assign wr_en       = wr_en_q;
  assign din         = din_q;
  assign tlp_count   = tlp_cnt_q;
  assign drop_count  = drop_cnt_q;
  assign trunc_count = trunc_cnt_q;

endmodule
